mem_wr_arbiter: RTL and testbench



---
 rtl/mem_wr_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_wr_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wr_arbiter.sv
// Round-robin write-port arbiter with burst locking for a single-write-port
// vector/weight memory; the write path to the memory is fully registered.
module mem_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATAW     = 64,
  parameter int DEPTH     = 256,
  parameter int ADDRW     = $clog2(DEPTH),
  parameter int MAX_BURST = 16,
  parameter int IDW       = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*ADDRW-1:0] req_addr,
  input  logic [NUM_REQ*DATAW-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     mem_wen,
  output logic [ADDRW-1:0]         mem_waddr,
  output logic [DATAW-1:0]         mem_wdata,
  output logic                     busy,
  output logic [IDW-1:0]           owner_id,
  output logic                     burst_trunc
);

  localparam int CNTW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  localparam logic [IDW:0]    NUM_REQ_W   = (IDW + 1)'(NUM_REQ);
  localparam logic [IDW-1:0]  LAST_IDX    = IDW'(NUM_REQ - 1);
  localparam logic [CNTW-1:0] MAX_BURST_C = CNTW'(MAX_BURST);

  logic [0:0]      state;
  logic [IDW-1:0]  rr_ptr;
  logic [CNTW-1:0] beat_cnt;

  logic            win_found;
  logic [IDW-1:0]  win_idx;
  logic [IDW:0]    cand_sum;
  logic [IDW-1:0]  sel_idx;
  logic            grant_any;
  logic            accept;
  logic            sel_last;
  logic [ADDRW-1:0] sel_addr;
  logic [DATAW-1:0] sel_data;
  logic [CNTW-1:0] beat_inc;
  logic            burst_end;

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + IDW'(1);
  endfunction

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr} + (IDW + 1)'(k);
      if (cand_sum >= NUM_REQ_W) cand_sum = cand_sum - NUM_REQ_W;
      if (!win_found && req_valid[cand_sum[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand_sum[IDW-1:0];
      end
    end
  end

  // In BURST the owner holds the port whether or not it is presenting a beat.
  assign sel_idx   = (state == S_BURST) ? owner_id : win_idx;
  assign grant_any = (state == S_BURST) || win_found;

  always_comb begin
    req_ready = '0;
    sel_last  = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    if (rst_n && grant_any) req_ready[sel_idx] = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == IDW'(i)) begin
        sel_last = req_last[i];
        sel_addr = req_addr[i*ADDRW +: ADDRW];
        sel_data = req_data[i*DATAW +: DATAW];
      end
    end
  end

  assign accept    = |(req_valid & req_ready);
  assign beat_inc  = (state == S_IDLE) ? CNTW'(1) : beat_cnt + CNTW'(1);
  // Covers both an explicit last beat and the forced release at MAX_BURST,
  // including MAX_BURST == 1 where every first beat ends the grant.
  assign burst_end = sel_last || (beat_inc == MAX_BURST_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      owner_id    <= '0;
      beat_cnt    <= '0;
      busy        <= 1'b0;
      burst_trunc <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      burst_trunc <= accept && burst_end && !sel_last;
      if (accept) begin
        owner_id <= sel_idx;
        beat_cnt <= beat_inc;
        if (burst_end) begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          rr_ptr <= next_idx(sel_idx);
        end else begin
          state  <= S_BURST;
          busy   <= 1'b1;
        end
      end
    end
  end

  // Write path: one-cycle latency, address/data hold when no beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wen   <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      mem_wen <= accept;
      if (accept) begin
        mem_waddr <= sel_addr;
        mem_wdata <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_wr_arbiter.sv
// Directed bench for mem_wr_arbiter: grant sequence, burst lock, truncation,
// bubbles and asynchronous reset, with a write scoreboard on the memory port.
module tb_mem_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATAW     = 64;
  localparam int DEPTH     = 256;
  localparam int ADDRW     = 8;
  localparam int MAX_BURST = 4;
  localparam int IDW       = 2;

  typedef struct packed {
    logic [ADDRW-1:0] addr;
    logic [DATAW-1:0] data;
  } beat_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ*ADDRW-1:0] req_addr;
  logic [NUM_REQ*DATAW-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     mem_wen;
  logic [ADDRW-1:0]         mem_waddr;
  logic [DATAW-1:0]         mem_wdata;
  logic                     busy;
  logic [IDW-1:0]           owner_id;
  logic                     burst_trunc;

  beat_t            sb[$];
  logic [DATAW-1:0] tb_mem  [DEPTH];
  logic [DATAW-1:0] exp_mem [DEPTH];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               seq      = 0;

  mem_wr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DATAW    (DATAW),
    .DEPTH    (DEPTH),
    .ADDRW    (ADDRW),
    .MAX_BURST(MAX_BURST),
    .IDW      (IDW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .mem_wen    (mem_wen),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .owner_id   (owner_id),
    .burst_trunc(burst_trunc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string what,
                     input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic l,
                         input logic [ADDRW-1:0] a);
    req_valid[i] = v;
    req_last[i]  = l;
    req_addr[i*ADDRW +: ADDRW] = a;
    req_data[i*DATAW +: DATAW] = {8'hA5, 8'(i), 24'h0, 16'(seq), a};
    seq++;
  endtask

  // Inputs are driven at posedge+1; ready is checked at posedge+4, the write
  // and registered status at the following posedge+1.
  task automatic step(input string tag, input logic [NUM_REQ-1:0] exp_ready,
                      input logic exp_busy, input logic exp_trunc);
    logic [NUM_REQ-1:0] acc;
    beat_t b;
    #3;
    chk(tag, "ready", 64'(req_ready), 64'(exp_ready));
    acc = exp_ready & req_valid;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        b.addr = req_addr[i*ADDRW +: ADDRW];
        b.data = req_data[i*DATAW +: DATAW];
        sb.push_back(b);
        exp_mem[b.addr] = b.data;
      end
    end
    @(posedge clk);
    #1;
    chk(tag, "wen", 64'(mem_wen), 64'(acc != '0));
    if (acc != '0 && sb.size() > 0) begin
      b = sb.pop_front();
      chk(tag, "waddr", 64'(mem_waddr), 64'(b.addr));
      chk(tag, "wdata", mem_wdata, b.data);
    end
    chk(tag, "busy", 64'(busy), 64'(exp_busy));
    chk(tag, "trunc", 64'(burst_trunc), 64'(exp_trunc));
    if (mem_wen) tb_mem[mem_waddr] = mem_wdata;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_last  = '0;
    req_addr  = '0;
    req_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i]  = '0;
      exp_mem[i] = '0;
    end

    // Reset with every requester valid.
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst", "ready", 64'(req_ready), 64'h0);
    chk("rst", "wen",   64'(mem_wen), 64'h0);
    chk("rst", "busy",  64'(busy), 64'h0);
    chk("rst", "owner", 64'(owner_id), 64'h0);
    chk("rst", "waddr", 64'(mem_waddr), 64'h0);
    chk("rst", "trunc", 64'(burst_trunc), 64'h0);
    rst_n = 1'b1;

    // Single beats from all four: round-robin 0,1,2,3,0.
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b1, 8'(i));
    step("single0", 4'b0001, 1'b0, 1'b0);
    step("single1", 4'b0010, 1'b0, 1'b0);
    step("single2", 4'b0100, 1'b0, 1'b0);
    step("single3", 4'b1000, 1'b0, 1'b0);
    step("single4", 4'b0001, 1'b0, 1'b0);
    chk("single4", "owner", 64'(owner_id), 64'h0);
    req_valid = '0;
    step("idle", 4'b0000, 1'b0, 1'b0);

    // Burst lock: req1 holds the port for 3 beats while req2 waits.
    set_req(2, 1'b1, 1'b1, 8'h20);
    set_req(1, 1'b1, 1'b0, 8'h10);
    step("lock1", 4'b0010, 1'b1, 1'b0);
    set_req(1, 1'b1, 1'b0, 8'h11);
    step("lock2", 4'b0010, 1'b1, 1'b0);
    set_req(1, 1'b1, 1'b1, 8'h12);
    step("lock3", 4'b0010, 1'b0, 1'b0);
    req_valid[1] = 1'b0;
    step("lock_next", 4'b0100, 1'b0, 1'b0);
    chk("lock_next", "owner", 64'(owner_id), 64'h2);
    req_valid = '0;
    for (int a = 16; a < 19; a++) chk("lock_mem", "word", tb_mem[a], exp_mem[a]);

    // Move the pointer back to requester 0.
    set_req(3, 1'b1, 1'b1, 8'h3F);
    step("pre_trunc", 4'b1000, 1'b0, 1'b0);

    // Truncation: req0 streams without last, forced release after 4 beats.
    set_req(3, 1'b1, 1'b1, 8'h40);
    for (int b = 0; b < 4; b++) begin
      set_req(0, 1'b1, 1'b0, 8'(8'h30 + b));
      step("trunc_beat", 4'b0001, (b != 3), (b == 3));
    end
    step("trunc_req3", 4'b1000, 1'b0, 1'b0);
    chk("trunc_req3", "owner", 64'(owner_id), 64'h3);
    req_valid[3] = 1'b0;
    set_req(0, 1'b1, 1'b0, 8'h34);
    step("trunc_b5", 4'b0001, 1'b1, 1'b0);
    set_req(0, 1'b1, 1'b1, 8'h35);
    step("trunc_b6", 4'b0001, 1'b0, 1'b0);
    req_valid = '0;

    // Bubble: owner req2 drops valid for two cycles while others wait.
    set_req(2, 1'b1, 1'b0, 8'h50);
    step("bub1", 4'b0100, 1'b1, 1'b0);
    set_req(2, 1'b1, 1'b0, 8'h51);
    step("bub2", 4'b0100, 1'b1, 1'b0);
    req_valid[2] = 1'b0;
    set_req(0, 1'b1, 1'b1, 8'h60);
    set_req(1, 1'b1, 1'b1, 8'h61);
    step("bub_gap1", 4'b0100, 1'b1, 1'b0);
    step("bub_gap2", 4'b0100, 1'b1, 1'b0);
    set_req(2, 1'b1, 1'b1, 8'h52);
    step("bub3", 4'b0100, 1'b0, 1'b0);
    req_valid[2] = 1'b0;
    step("bub_after0", 4'b0001, 1'b0, 1'b0);
    req_valid[0] = 1'b0;
    step("bub_after1", 4'b0010, 1'b0, 1'b0);
    req_valid = '0;

    // Asynchronous reset during beat 2 of a 5-beat burst from req1.
    set_req(1, 1'b1, 1'b0, 8'h70);
    step("arst_b1", 4'b0010, 1'b1, 1'b0);
    set_req(1, 1'b1, 1'b0, 8'h71);
    #3;
    chk("arst_b2", "ready", 64'(req_ready), 64'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst", "ready", 64'(req_ready), 64'h0);
    chk("arst", "wen",   64'(mem_wen), 64'h0);
    chk("arst", "busy",  64'(busy), 64'h0);
    chk("arst", "owner", 64'(owner_id), 64'h0);
    chk("arst", "waddr", 64'(mem_waddr), 64'h0);
    chk("arst", "wdata", mem_wdata, 64'h0);
    @(posedge clk);
    #1;
    chk("arst_hold", "wen", 64'(mem_wen), 64'h0);
    rst_n = 1'b1;
    set_req(0, 1'b1, 1'b1, 8'h80);
    set_req(1, 1'b1, 1'b1, 8'h81);
    step("arst_g0", 4'b0001, 1'b0, 1'b0);
    req_valid[0] = 1'b0;
    step("arst_g1", 4'b0010, 1'b0, 1'b0);
    req_valid = '0;
    step("final_idle", 4'b0000, 1'b0, 1'b0);
    chk("final", "sb_empty", 64'(sb.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
